// File: rtl/arbitro_rr_4a1_if.sv
// arbitro_rr_4a1_if: four input FIFO read ports plus one output FIFO write port of the merge arbiter
interface arbitro_rr_4a1_if #(parameter int DATA_WIDTH = 6);
    logic                  empty0, empty1, empty2, empty3;
    logic [DATA_WIDTH-1:0] data_in0, data_in1, data_in2, data_in3;
    logic                  almost_full;
    logic                  pop0, pop1, pop2, pop3;
    logic                  push;
    logic [DATA_WIDTH-1:0] data_out;
    logic [1:0]            sel;
    modport master (
        input  empty0, empty1, empty2, empty3,
        input  data_in0, data_in1, data_in2, data_in3,
        input  almost_full,
        output pop0, pop1, pop2, pop3,
        output push, data_out, sel
    );
    modport slave (
        output empty0, empty1, empty2, empty3,
        output data_in0, data_in1, data_in2, data_in3,
        output almost_full,
        input  pop0, pop1, pop2, pop3,
        input  push, data_out, sel
    );
endinterface

// File: rtl/arbitro_rr_4a1.sv
// arbitro_rr_4a1: four-to-one round-robin merge of four input FIFOs into one output FIFO
module arbitro_rr_4a1 #(
    parameter int         DATA_WIDTH = 6,
    parameter logic [3:0] INIT_STATE = 4'b0001
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [3:0]       state,
    arbitro_rr_4a1_if.master bus
);
    logic [1:0]            ptr, grant;
    logic [3:0]            req, pop;
    logic                  enable, any_req, init;
    logic [DATA_WIDTH-1:0] din [4];
    assign req     = ~{bus.empty3, bus.empty2, bus.empty1, bus.empty0};
    assign din     = '{bus.data_in0, bus.data_in1, bus.data_in2, bus.data_in3};
    assign any_req = |req;
    assign init    = state == INIT_STATE;
    assign enable  = reset_L & ~init & ~bus.almost_full;
    // Scan from the farthest offset back to ptr so the nearest requester wins.
    always_comb begin
        grant = ptr;
        for (int i = 3; i >= 0; i--)
            if (req[ptr + 2'(i)]) grant = ptr + 2'(i);
    end
    assign pop      = (enable && any_req) ? 4'b0001 << grant : 4'b0000;
    assign bus.pop0 = pop[0];
    assign bus.pop1 = pop[1];
    assign bus.pop2 = pop[2];
    assign bus.pop3 = pop[3];
    always_ff @(posedge clk or negedge reset_L)
        if (!reset_L || init) begin
            ptr          <= '0;
            bus.push     <= 1'b0;
            bus.data_out <= '0;
            bus.sel      <= '0;
        end else begin
            bus.push <= |pop;
            if (|pop) begin
                ptr          <= grant + 2'd1;
                bus.data_out <= din[grant];
                bus.sel      <= grant;
            end
        end
endmodule

// File: tb/tb_arbitro_rr_4a1.sv
// tb_arbitro_rr_4a1: directed checks of rotation, skipping, back-pressure, init and reset
module tb_arbitro_rr_4a1;
    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic [3:0] state = 4'b0010;
    int         tests = 0;
    int         fails = 0;
    int         cnt [4];
    arbitro_rr_4a1_if #(.DATA_WIDTH(6)) bus ();
    arbitro_rr_4a1 #(.DATA_WIDTH(6), .INIT_STATE(4'b0001)) dut (
        .clk(clk), .reset_L(reset_L), .state(state), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic drive();
        bus.empty0 = cnt[0] == 0;
        bus.empty1 = cnt[1] == 0;
        bus.empty2 = cnt[2] == 0;
        bus.empty3 = cnt[3] == 0;
    endtask
    function automatic logic [3:0] pops();
        return {bus.pop3, bus.pop2, bus.pop1, bus.pop0};
    endfunction
    // Check pops this cycle, clock once, then check what was pushed.
    task automatic step(input logic [3:0] ep, input logic eq, input logic [1:0] es, input logic [5:0] ed);
        logic [3:0] p;
        drive();
        #1;
        p = pops();
        chk("pop", {4'b0, p}, {4'b0, ep});
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (p[i]) cnt[i]--;
        chk("push", {7'b0, bus.push}, {7'b0, eq});
        chk("sel", {6'b0, bus.sel}, {6'b0, es});
        chk("data_out", {2'b0, bus.data_out}, {2'b0, ed});
    endtask
    initial begin
        bus.data_in0 = 6'h0A;
        bus.data_in1 = 6'h0B;
        bus.data_in2 = 6'h0C;
        bus.data_in3 = 6'h0D;
        bus.almost_full = 1'b0;
        cnt = '{2, 2, 2, 2};
        drive();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_push", {7'b0, bus.push}, 8'h0);
        chk("rst_pop", {4'b0, pops()}, 8'h0);
        chk("rst_data", {2'b0, bus.data_out}, 8'h0);
        chk("rst_sel", {6'b0, bus.sel}, 8'h0);
        chk("rst_ptr", {6'b0, dut.ptr}, 8'h0);
        reset_L = 1'b1;
        for (int i = 0; i < 8; i++)
            step(4'b0001 << (i % 4), 1'b1, 2'(i % 4), 6'h0A + 6'(i % 4));
        step(4'b0000, 1'b0, 2'd3, 6'h0D);
        chk("rr_ptr", {6'b0, dut.ptr}, 8'h0);
        cnt = '{0, 2, 0, 1};
        step(4'b0010, 1'b1, 2'd1, 6'h0B);
        step(4'b1000, 1'b1, 2'd3, 6'h0D);
        step(4'b0010, 1'b1, 2'd1, 6'h0B);
        step(4'b0000, 1'b0, 2'd1, 6'h0B);
        chk("skip_ptr", {6'b0, dut.ptr}, 8'h2);
        cnt = '{3, 3, 3, 3};
        step(4'b0100, 1'b1, 2'd2, 6'h0C);
        step(4'b1000, 1'b1, 2'd3, 6'h0D);
        bus.almost_full = 1'b1;
        #1;
        chk("bp_push_tail", {7'b0, bus.push}, 8'h1);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 2'd3, 6'h0D);
        chk("bp_ptr", {6'b0, dut.ptr}, 8'h0);
        bus.almost_full = 1'b0;
        step(4'b0001, 1'b1, 2'd0, 6'h0A);
        step(4'b0010, 1'b1, 2'd1, 6'h0B);
        step(4'b0100, 1'b1, 2'd2, 6'h0C);
        cnt = '{2, 2, 2, 2};
        state = 4'b0001;
        step(4'b0000, 1'b0, 2'd0, 6'h00);
        step(4'b0000, 1'b0, 2'd0, 6'h00);
        chk("init_ptr", {6'b0, dut.ptr}, 8'h0);
        state = 4'b0010;
        step(4'b0001, 1'b1, 2'd0, 6'h0A);
        step(4'b0010, 1'b1, 2'd1, 6'h0B);
        chk("pre_rst_ptr", {6'b0, dut.ptr}, 8'h2);
        reset_L = 1'b0;
        #1;
        chk("arst_push", {7'b0, bus.push}, 8'h0);
        chk("arst_data", {2'b0, bus.data_out}, 8'h0);
        chk("arst_sel", {6'b0, bus.sel}, 8'h0);
        chk("arst_pop", {4'b0, pops()}, 8'h0);
        chk("arst_ptr", {6'b0, dut.ptr}, 8'h0);
        #1;
        reset_L = 1'b1;
        step(4'b0001, 1'b1, 2'd0, 6'h0A);
        cnt = '{0, 0, 4, 0};
        for (int i = 0; i < 4; i++) step(4'b0100, 1'b1, 2'd2, 6'h0C);
        step(4'b0000, 1'b0, 2'd2, 6'h0C);
        chk("single_ptr", {6'b0, dut.ptr}, 8'h3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
